// File: rtl/imm_pack.sv
// imm_pack: packs a signed 32-bit immediate into the RISC-V I/S/B/J immediate
// bit positions of a base instruction word, with range/alignment checking.
// This is the inverse of the immediate extender and feeds the instruction
// memory preload / self-test loader through a one-deep valid/ready stage.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input word offered
//   in_ready   block can accept input this cycle (combinational)
//   imm        signed immediate to encode
//   immsrc     00 I-type, 01 S-type, 10 B-type, 11 J-type
//   base       instruction with non-immediate fields (immediate bits ignored)
//   out_valid  encoded word available
//   out_ready  downstream accepts word
//   instr      encoded instruction
//   out_err    immediate not representable for immsrc (qualified by out_valid)
//   word_cnt   words emitted, wraps
//   err_cnt    errored inputs accepted, saturates at all-ones
//
// Optional feature macro: IMM_PACK_DROP_ERR_EN
//   defined   : errored inputs are consumed but produce no output word;
//               out_err is tied 0, err_cnt still counts them.
//   undefined : errored words are emitted with out_err=1.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The producer holds valid and its payload stable until that edge; ready
// may change freely. in_ready = !out_valid || out_ready, so a word can be
// taken whenever the output stage is empty or is being drained this cycle.

module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [1:0]       immsrc,
    input  logic [31:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        SRC_I = 2'b00,
        SRC_S = 2'b01,
        SRC_B = 2'b10,
        SRC_J = 2'b11
    } imm_src_e;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        accept;
    logic        consume;
    logic        emit;
    logic [31:0] pack_word;
    logic        pack_err;

    // Sign-range checks: the bits above the top encodable bit must all equal
    // the top encodable bit, i.e. the slice is all ones or all zeros.
    logic sext_ok_11;
    logic sext_ok_12;
    logic sext_ok_20;

    assign sext_ok_11 = (&imm[31:11]) || !(|imm[31:11]);
    assign sext_ok_12 = (&imm[31:12]) || !(|imm[31:12]);
    assign sext_ok_20 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        pack_word = base;
        pack_err  = 1'b0;
        case (imm_src_e'(immsrc))
            SRC_I: begin
                pack_word = {imm[11:0], base[19:0]};
                pack_err  = !sext_ok_11;
            end
            SRC_S: begin
                pack_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                pack_err  = !sext_ok_11;
            end
            SRC_B: begin
                pack_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                pack_err  = !sext_ok_12 || imm[0];
            end
            SRC_J: begin
                pack_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                pack_err  = !sext_ok_20 || imm[0];
            end
            default: begin
                pack_word = base;
                pack_err  = 1'b0;
            end
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

`ifdef IMM_PACK_DROP_ERR_EN
    // Errored words are swallowed: accepted but never presented.
    assign emit    = accept && !pack_err;
    assign out_err = 1'b0;
`else
    logic out_err_q, out_err_d;

    assign emit    = accept;
    assign out_err = out_err_q;

    always_comb begin
        out_err_d = out_err_q;
        if (emit) begin
            out_err_d = pack_err;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;

        // Accept takes priority: a simultaneous consume + accept reloads the
        // register and keeps out_valid high (unless the new word is dropped).
        if (accept) begin
            out_valid_d = emit;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        // Load only on emit so idle-cycle X on imm/base never reaches instr.
        if (emit) begin
            instr_d = pack_word;
        end

        if (consume) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end

        if (accept && pack_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: directed and streamed checks for imm_pack.
// Expected values come from hand-computed vectors and from an independent
// reference extender (instr -> imm) plus a signed range model for errors.
// Compile with +define+IMM_PACK_DROP_ERR_EN to check the drop variant.

module tb_imm_pack;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      imm;
    logic [1:0]       immsrc;
    logic [31:0]      base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             out_err;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_vec;
    int n_fail;
    int exp_words;
    int exp_errs;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  src;
        logic [31:0] base;
        logic        err;
    } item_t;

    item_t exp_q[$];

`ifdef IMM_PACK_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    imm_pack #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .immsrc    (immsrc),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .out_err   (out_err),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] s);
        case (s)
            2'b00:   ref_ext = {{20{w[31]}}, w[31:20]};
            2'b01:   ref_ext = {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10:   ref_ext = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: ref_ext = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic ref_err(input logic [31:0] v, input logic [1:0] s);
        int sv;
        sv = $signed(v);
        case (s)
            2'b00, 2'b01: ref_err = (sv < -2048) || (sv > 2047);
            2'b10:        ref_err = (sv < -4096) || (sv > 4094) || v[0];
            default:      ref_err = (sv < -1048576) || (sv > 1048574) || v[0];
        endcase
    endfunction

    // Bits of the instruction that carry the immediate for each format.
    function automatic logic [31:0] imm_mask(input logic [1:0] s);
        case (s)
            2'b00:        imm_mask = 32'hFFF0_0000;
            2'b01, 2'b10: imm_mask = 32'hFE00_0F80;
            default:      imm_mask = 32'hFFFF_F000;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Offers one word starting just after a posedge; assumes in_ready=1.
    task automatic offer(input logic [31:0] i, input logic [1:0] s, input logic [31:0] b);
        imm      = i;
        immsrc   = s;
        base     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        imm      = 'x;
        base     = 'x;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm       = 32'h0;
        immsrc    = 2'b00;
        base      = 32'h0;
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        n_vec++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        n_vec++; if (word_cnt !== '0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
        n_vec++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_i_type;
        offer(32'hFFFF_FFFF, 2'b00, 32'h0000_0013);
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL i_valid: got %b want 1", out_valid); end
        n_vec++; if (instr !== 32'hFFF0_0013) begin n_fail++; $display("FAIL i_instr: got %h want fff00013", instr); end
        n_vec++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL i_err: got %b want 0", out_err); end
        @(posedge clk);
        #1;
        exp_words++;
        n_vec++; if (word_cnt !== CNT_W'(exp_words)) begin n_fail++; $display("FAIL i_word_cnt: got %0d want %0d", word_cnt, exp_words); end
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_b_type;
        offer(32'h0000_0FFE, 2'b10, 32'h0000_0063);
        n_vec++; if (instr !== 32'h7E00_0FE3) begin n_fail++; $display("FAIL b_instr: got %h want 7e000fe3", instr); end
        n_vec++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL b_err: got %b want 0", out_err); end
        // Back-to-back: previous word consumed on the same edge this one is taken.
        offer(32'h0000_0003, 2'b10, 32'h0000_0063);
        exp_words++;
        exp_errs++;
        n_vec++; if (err_cnt !== CNT_W'(exp_errs)) begin n_fail++; $display("FAIL b_odd_err_cnt: got %0d want %0d", err_cnt, exp_errs); end
        if (!DROP) begin
            n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b_odd_valid: got %b want 1", out_valid); end
            n_vec++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL b_odd_err: got %b want 1", out_err); end
            n_vec++; if (instr !== 32'h0000_0163) begin n_fail++; $display("FAIL b_odd_instr: got %h want 00000163", instr); end
            exp_words++;
        end else begin
            n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b_odd_dropped: got %b want 0", out_valid); end
            n_vec++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL b_odd_err_tied: got %b want 0", out_err); end
        end
        @(posedge clk);
        #1;
        n_vec++; if (word_cnt !== CNT_W'(exp_words)) begin n_fail++; $display("FAIL b_word_cnt: got %0d want %0d", word_cnt, exp_words); end
    endtask

    task automatic test_j_s;
        offer(32'hFFFF_FFFE, 2'b11, 32'h0000_006F);
        n_vec++; if (instr !== 32'hFFFF_F06F) begin n_fail++; $display("FAIL j_instr: got %h want fffff06f", instr); end
        n_vec++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL j_err: got %b want 0", out_err); end
        offer(32'h0000_0804, 2'b01, 32'h0000_0023);
        exp_words++;
        exp_errs++;
        n_vec++; if (err_cnt !== CNT_W'(exp_errs)) begin n_fail++; $display("FAIL s_err_cnt: got %0d want %0d", err_cnt, exp_errs); end
        if (!DROP) begin
            n_vec++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL s_err: got %b want 1", out_err); end
            n_vec++; if (instr !== 32'h8000_0223) begin n_fail++; $display("FAIL s_instr: got %h want 80000223", instr); end
            exp_words++;
        end else begin
            n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL s_dropped: got %b want 0", out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundaries;
        logic [31:0] t_imm [12];
        logic [1:0]  t_src [12];
        logic        t_err [12];
        logic [31:0] b;
        t_imm = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF,
                  32'h0000_07FF, 32'hFFFF_F000, 32'h0000_1000, 32'hFFFF_EFFE,
                  32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000, 32'h0000_0001};
        t_src = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10,
                  2'b11, 2'b11, 2'b11, 2'b11};
        t_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 12; k++) begin
            b = 32'h0AB5_5A5A ^ (32'(k) << 3);
            offer(t_imm[k], t_src[k], b);
            if (t_err[k]) exp_errs++;
            n_vec++; if (err_cnt !== CNT_W'(exp_errs)) begin n_fail++; $display("FAIL bnd%0d_err_cnt: got %0d want %0d", k, err_cnt, exp_errs); end
            if (DROP && t_err[k]) begin
                n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bnd%0d_dropped: got %b want 0", k, out_valid); end
            end else begin
                exp_words++;
                n_vec++; if (out_err !== (DROP ? 1'b0 : t_err[k])) begin n_fail++; $display("FAIL bnd%0d_err: got %b want %b", k, out_err, t_err[k]); end
                if (!t_err[k]) begin
                    n_vec++; if (ref_ext(instr, t_src[k]) !== t_imm[k]) begin n_fail++; $display("FAIL bnd%0d_roundtrip: got %h want %h", k, ref_ext(instr, t_src[k]), t_imm[k]); end
                end
                n_vec++; if ((instr & ~imm_mask(t_src[k])) !== (b & ~imm_mask(t_src[k]))) begin n_fail++; $display("FAIL bnd%0d_passthru: got %h want %h", k, instr, b); end
            end
            @(posedge clk);
            #1;
        end
        n_vec++; if (word_cnt !== CNT_W'(exp_words)) begin n_fail++; $display("FAIL bnd_word_cnt: got %0d want %0d", word_cnt, exp_words); end
    endtask

    task automatic test_backpressure;
        logic [31:0] e [4];
        for (int k = 0; k < 4; k++) e[k] = (32'(k + 1) << 20) | 32'h13;
        out_ready = 1'b0;
        offer(32'd1, 2'b00, 32'h13);
        imm      = 32'd2;
        immsrc   = 2'b00;
        base     = 32'h13;
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_vec++; if (instr !== e[0]) begin n_fail++; $display("FAIL bp_stall%0d_instr: got %h want %h", s, instr, e[0]); end
            n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall%0d_valid: got %b want 1", s, out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d_in_ready: got %b want 0", s, in_ready); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_word%0d_valid: got %b want 1", k, out_valid); end
            n_vec++; if (instr !== e[k]) begin n_fail++; $display("FAIL bp_word%0d_instr: got %h want %h", k, instr, e[k]); end
            @(posedge clk);
            #1;
            exp_words++;
            if (k + 2 <= 3) begin
                imm = 32'(k + 3);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        n_vec++; if (word_cnt !== CNT_W'(exp_words)) begin n_fail++; $display("FAIL bp_word_cnt: got %0d want %0d", word_cnt, exp_words); end
        @(posedge clk);
        #1;
    endtask

    task automatic gen(output logic [31:0] gi, output logic [1:0] gs);
        logic [31:0] v;
        logic        bad;
        gs  = 2'($urandom_range(0, 3));
        bad = ($urandom_range(0, 7) == 0);
        case (gs)
            2'b00, 2'b01: begin
                v  = $urandom_range(0, 4095);
                gi = {{20{v[11]}}, v[11:0]};
                if (bad) gi = v[0] ? (32'd2048 + $urandom_range(0, 1 << 20))
                                   : (32'hFFFF_F7FF - $urandom_range(0, 1 << 20));
            end
            2'b10: begin
                v  = $urandom_range(0, 8191);
                gi = {{19{v[12]}}, v[12:1], 1'b0};
                if (bad) gi = gi | 32'h1;
            end
            default: begin
                v  = $urandom_range(0, (1 << 21) - 1);
                gi = {{11{v[20]}}, v[20:1], 1'b0};
                if (bad) gi = v[1] ? (gi | 32'h1) : (gi ^ 32'h4000_0000);
            end
        endcase
    endtask

    task automatic test_round_trip;
        int    sent;
        int    cyc;
        item_t it;
        item_t got;
        logic  have;
        sent = 0;
        have = 1'b0;
        for (cyc = 0; cyc < 60000 && (sent < 10000 || have || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL rt_extra_word: got %h want none", instr);
                end else begin
                    got = exp_q.pop_front();
                    exp_words++;
                    n_vec++; if (out_err !== (DROP ? 1'b0 : got.err)) begin n_fail++; $display("FAIL rt_err: got %b want %b imm %h src %0d", out_err, got.err, got.imm, got.src); end
                    if (!got.err) begin
                        n_vec++; if (ref_ext(instr, got.src) !== got.imm) begin n_fail++; $display("FAIL rt_imm: got %h want %h src %0d", ref_ext(instr, got.src), got.imm, got.src); end
                    end
                    n_vec++; if ((instr & ~imm_mask(got.src)) !== (got.base & ~imm_mask(got.src))) begin n_fail++; $display("FAIL rt_passthru: got %h want %h", instr, got.base); end
                end
            end
            if (in_valid && in_ready) begin
                if (it.err) exp_errs++;
                if (!(DROP && it.err)) exp_q.push_back(it);
                have = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
            if (!have && sent < 10000 && ($urandom_range(0, 4) != 0)) begin
                gen(it.imm, it.src);
                it.base = $urandom;
                it.err  = ref_err(it.imm, it.src);
                have    = 1'b1;
            end
            in_valid  = have;
            imm       = it.imm;
            immsrc    = it.src;
            base      = it.base;
            out_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sent < 10000 || exp_q.size() > 0) begin
            n_vec++; n_fail++;
            $display("FAIL rt_timeout: got %0d sent %0d pending want 10000 sent 0 pending", sent, exp_q.size());
        end
        @(negedge clk);
        n_vec++; if (word_cnt !== CNT_W'(exp_words)) begin n_fail++; $display("FAIL rt_word_cnt: got %0d want %0d", word_cnt, CNT_W'(exp_words)); end
        n_vec++; if (err_cnt !== CNT_W'(exp_errs)) begin n_fail++; $display("FAIL rt_err_cnt: got %0d want %0d", err_cnt, CNT_W'(exp_errs)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        offer(32'h0000_0123, 2'b00, 32'h0000_0013);
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pending: got %b want 1", out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
        n_vec++; if (word_cnt !== '0) begin n_fail++; $display("FAIL mr_word_cnt: got %0d want 0", word_cnt); end
        n_vec++; if (err_cnt !== '0) begin n_fail++; $display("FAIL mr_err_cnt: got %0d want 0", err_cnt); end
        n_vec++; if (instr !== 32'h0) begin n_fail++; $display("FAIL mr_instr: got %h want 00000000", instr); end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_after_release: got %b want 0", out_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec     = 0;
        n_fail    = 0;
        exp_words = 0;
        exp_errs  = 0;
        test_reset();
        test_i_type();
        test_b_type();
        test_j_s();
        test_boundaries();
        test_backpressure();
        test_round_trip();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Inverse of the immediate extender: takes a signed 32-bit immediate plus a base instruction word (opcode/rd/rs/funct fields) and packs the immediate into the RISC-V I/S/B/J bit positions.
- Sits in the instruction-memory preload/self-test path. Feeds encoded words to the loader through a valid/ready stream.
- Performs range and alignment checking and keeps running counts of words and errors.
- Round-trip property: for every error-free word, re-extending instr[31:7] with the same immsrc returns imm exactly.

Parameters:
- CNT_W, 16, width of word_cnt and err_cnt (minimum 4).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept input this cycle
- imm  in  32  signed immediate to encode
- immsrc  in  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- base  in  32  instruction with non-immediate fields; bits in the immediate field are ignored
- out_valid  out  1  encoded word available
- out_ready  in  1  downstream accepts word
- instr  out  32  encoded instruction
- out_err  out  1  imm not representable for immsrc; qualified by out_valid
- word_cnt  out  CNT_W  words emitted; wraps modulo 2^CNT_W
- err_cnt  out  CNT_W  errored inputs accepted; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): out_valid=0, instr=0, out_err=0, word_cnt=0, err_cnt=0. A pending output word is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Input is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
  - Latency is 1 cycle: an accepted input is presented on the next cycle.
  - Full throughput of one word per cycle while out_ready=1.
  - Simultaneous consume and accept: the output register reloads and out_valid stays 1.
  - Consume with no accept: out_valid goes to 0.
  - While out_valid=1 && out_ready=0: instr and out_err hold stable and in_ready=0.
- Encoding. All bits of base outside the immediate field pass through unchanged.
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1], instr[7]=imm[11].
  - J: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12].
- Error rules. The error flag is computed in the accept cycle and registered with instr.
  - I/S: error if imm[31:11] is not all-equal (range -2048..2047).
  - B: error if imm[31:12] is not all-equal, or imm[0]=1 (range -4096..4094, even).
  - J: error if imm[31:20] is not all-equal, or imm[0]=1 (range -1048576..1048574, even).
  - On error, instr still carries the truncated field packing.
- Counters:
  - word_cnt increments on each output consume and wraps from all-ones to 0.
  - err_cnt increments on each accepted input whose error flag is 1 and holds at all-ones.
  - Both counters update in the same cycle as the triggering event.
- immsrc has no illegal encodings. X on imm or base while in_valid=0 must not propagate to outputs.

Optional Feature:
- Macro IMM_PACK_DROP_ERR_EN.
- Defined:
  - An accepted input whose error flag is 1 is consumed, but no output word is produced; out_valid does not assert for it.
  - err_cnt still increments. out_err is tied 0.
  - in_ready follows the same equation.
- Undefined: errored words are emitted with out_err=1, as described above.

Test Plan:
- Reset mid-stream: hold out_ready=0 with a word pending, pulse reset_n=0 -> out_valid=0, word_cnt=0, err_cnt=0 immediately, without waiting for a clock edge.
- I-type: imm=0xFFFFFFFF, base=0x00000013, immsrc=00 -> next cycle instr=0xFFF00013, out_err=0, word_cnt=1.
- B-type: imm=0x00000FFE, base=0x00000063, immsrc=10 -> instr=0x7E000FE3, out_err=0. Repeat with imm=0x00000003 -> out_err=1 (macro undefined), err_cnt=1.
- J-type: imm=0xFFFFFFFE, base=0x0000006F, immsrc=11 -> instr=0xFFFFF06F. S-type imm=0x00000804 -> out_err=1.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles then 1 -> instr stable while stalled, in_ready=0 while full, all 4 words delivered in order, word_cnt=4, no loss or duplication.
- Random round-trip: 10k random legal (imm, immsrc) pairs -> a reference extender applied to instr[31:7] equals imm every time. With IMM_PACK_DROP_ERR_EN defined, illegal pairs produce no output and err_cnt matches the number of illegal pairs injected.
